// File: rtl/mmio_pkg.sv
// Shared constants for the switch/LED MMIO peripheral and its system decoder.
// No logic; constants only.
// Not applicable: no data path, no backpressure.
package mmio_pkg;

  // Register offsets within the peripheral window
  localparam logic [1:0] MMIO_SWDATA = 2'd0;
  localparam logic [1:0] MMIO_LED    = 2'd1;
  localparam logic [1:0] MMIO_STATUS = 2'd2;
  localparam logic [1:0] MMIO_CTRL   = 2'd3;

  // Bit positions inside STATUS and CTRL
  localparam int STATUS_CHG_BIT = 0;
  localparam int CTRL_IE_BIT    = 0;

  // Base of the I/O window the system decoder matches to raise cs
  localparam logic [15:0] MMIO_IO_BASE = 16'hFF00;

endpackage

// File: rtl/sw_debounce.sv
// Two-flop synchroniser plus whole-vector debounce for the raw switch bank.
// Latency: clean step reaches o_sw_stable 2 + DB_CYCLES + 1 cycles after the input edge.
// No backpressure: samples every cycle; o_commit is a combinational pulse on the commit edge.
module sw_debounce #(
  parameter int N_SW      = 10,
  parameter int DB_CYCLES = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_SW-1:0] i_sw,
  output logic [N_SW-1:0] o_sw_stable,
  output logic            o_commit
);

  localparam int CNT_W = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  logic [N_SW-1:0]  r_sync1;
  logic [N_SW-1:0]  r_sync2;
  logic [N_SW-1:0]  r_cand;
  logic [CNT_W-1:0] r_cnt;
  logic [N_SW-1:0]  r_stable;
  logic             w_commit;

  // The commit is asserted on the same edge that loads r_stable so the top
  // level can set its change flag in lockstep with the new switch value.
  assign w_commit = (r_sync2 == r_cand) && (r_cnt == CNT_MAX) && (r_cand != r_stable);

  // Synchronise, then track a candidate vector and accept it once it has held long enough
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_cand   <= '0;
      r_cnt    <= '0;
      r_stable <= '0;
    end else begin
      r_sync1 <= i_sw;
      r_sync2 <= r_sync1;
      if (r_sync2 != r_cand) begin
        r_cand <= r_sync2;
        r_cnt  <= '0;
      end else if (r_cnt < CNT_MAX) begin
        r_cnt <= r_cnt + 1'b1;
      end else if (w_commit) begin
        r_stable <= r_cand;
      end
    end
  end

  assign o_sw_stable = r_stable;
  assign o_commit    = w_commit;

endmodule

// File: rtl/mmio_sw_led.sv
// Switch/LED MMIO responder: debounced switch readback, LED register, change flag and level irq.
// Latency: writes land at the strobe edge; reads respond with rvalid/rdata one cycle later.
// No backpressure: every cs-qualified strobe is accepted; back-to-back reads every cycle.
module mmio_sw_led
  import mmio_pkg::*;
#(
  parameter int N_SW      = 10,
  parameter int DATA_W    = 16,
  parameter int DB_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs,
  input  logic [1:0]        addr,
  input  logic              we,
  input  logic              re,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  input  logic [N_SW-1:0]   SW,
  output logic [N_SW-1:0]   LEDR,
  output logic              irq
);

  logic [N_SW-1:0]   w_sw_stable;
  logic              w_commit;
  logic              w_wr;
  logic              w_rd;
  logic [DATA_W-1:0] w_rd_val;
  logic              w_unused;

  logic [N_SW-1:0]   r_led;
  logic              r_chg;
  logic              r_ie;
  logic [DATA_W-1:0] r_rdata;
  logic              r_rvalid;
  logic              r_irq;

  sw_debounce #(
    .N_SW      (N_SW),
    .DB_CYCLES (DB_CYCLES)
  ) u_sw_debounce (
    .clk         (clk),
    .rst         (rst),
    .i_sw        (SW),
    .o_sw_stable (w_sw_stable),
    .o_commit    (w_commit)
  );

  // A simultaneous write suppresses the read: no response and no STATUS clear.
  assign w_wr = cs & we;
  assign w_rd = cs & re & ~we;

  // Upper write-data bits have no register behind them.
  assign w_unused = ^wdata;

  // Zero-extended readback mux over the four registers
  always_comb begin
    w_rd_val = '0;
    case (addr)
      MMIO_SWDATA: w_rd_val[N_SW-1:0]     = w_sw_stable;
      MMIO_LED:    w_rd_val[N_SW-1:0]     = r_led;
      MMIO_STATUS: w_rd_val[STATUS_CHG_BIT] = r_chg;
      MMIO_CTRL:   w_rd_val[CTRL_IE_BIT]    = r_ie;
      default:     w_rd_val = '0;
    endcase
  end

  // Writable registers and the change flag; a new commit outranks the read-clear
  always_ff @(posedge clk) begin
    if (rst) begin
      r_led <= '0;
      r_ie  <= 1'b0;
      r_chg <= 1'b0;
    end else begin
      if (w_wr && addr == MMIO_LED) r_led <= wdata[N_SW-1:0];
      if (w_wr && addr == MMIO_CTRL) r_ie <= wdata[CTRL_IE_BIT];
      if (w_commit) begin
        r_chg <= 1'b1;
      end else if (w_rd && addr == MMIO_STATUS) begin
        r_chg <= 1'b0;
      end
    end
  end

  // Read response: captures pre-clear values one cycle after the strobe, zero when idle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= w_rd;
      r_rdata  <= w_rd ? w_rd_val : '0;
    end
  end

  // Registered level interrupt following chg AND ie
  always_ff @(posedge clk) begin
    if (rst) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= r_chg & r_ie;
    end
  end

  assign rdata  = r_rdata;
  assign rvalid = r_rvalid;
  assign LEDR   = r_led;
  assign irq    = r_irq;

endmodule

// File: tb/tb_mmio_sw_led.sv
// Self-checking bench for mmio_sw_led: directed steps plus a cycle reference model.
// The model keeps a history of sampled switch values and commits a vector once it has
// been seen unchanged for DB+1 consecutive debounce samples (sync delay of two edges).
module tb_mmio_sw_led;

  localparam int DB = 4;
  localparam logic [1:0] A_SW   = 2'd0;
  localparam logic [1:0] A_LED  = 2'd1;
  localparam logic [1:0] A_ST   = 2'd2;
  localparam logic [1:0] A_CTRL = 2'd3;

  logic        clk;
  logic        rst;
  logic        cs;
  logic [1:0]  addr;
  logic        we;
  logic        re;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        rvalid;
  logic [9:0]  SW;
  logic [9:0]  LEDR;
  logic        irq;

  int errors = 0;
  int checks = 0;

  // reference model state
  logic [9:0]  m_stable;
  logic [9:0]  m_led;
  logic        m_chg;
  logic        m_ie;
  logic        m_irq;
  logic        m_rvalid;
  logic [15:0] m_rdata;
  logic [9:0]  q[$];

  mmio_sw_led #(.N_SW(10), .DATA_W(16), .DB_CYCLES(DB)) dut (
    .clk(clk), .rst(rst), .cs(cs), .addr(addr), .we(we), .re(re),
    .wdata(wdata), .rdata(rdata), .rvalid(rvalid),
    .SW(SW), .LEDR(LEDR), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    repeat (DB + 3) q.push_back(10'h000);
    m_stable = '0; m_led = '0; m_chg = 1'b0; m_ie = 1'b0;
    m_irq = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
  endtask

  // Advance the model across one rising edge using the inputs currently driven
  task automatic model_edge();
    logic       rd_now;
    logic       wr_now;
    logic       commit;
    logic [9:0] x;
    int         n;
    if (rst) begin
      model_reset();
    end else begin
      rd_now = cs & re & ~we;
      wr_now = cs & we;
      q.push_back(SW);
      n = q.size();
      x = q[n-3];
      commit = (x != m_stable);
      for (int j = n - 3 - DB; j < n - 3; j++)
        if (q[j] != x) commit = 1'b0;
      m_rvalid = rd_now;
      m_rdata  = '0;
      if (rd_now) begin
        if (addr == A_SW)   m_rdata = {6'b0, m_stable};
        if (addr == A_LED)  m_rdata = {6'b0, m_led};
        if (addr == A_ST)   m_rdata = {15'b0, m_chg};
        if (addr == A_CTRL) m_rdata = {15'b0, m_ie};
      end
      m_irq = m_chg & m_ie;
      if (commit) begin
        m_stable = x;
        m_chg    = 1'b1;
      end else if (rd_now && addr == A_ST) begin
        m_chg = 1'b0;
      end
      if (wr_now && addr == A_LED)  m_led = wdata[9:0];
      if (wr_now && addr == A_CTRL) m_ie  = wdata[0];
      if (q.size() > 40) void'(q.pop_front());
    end
  endtask

  // One clock with the present inputs; outputs compared at the following falling edge
  task automatic cyc();
    model_edge();
    @(negedge clk);
    chk("ledr",   {6'b0, LEDR},    {6'b0, m_led});
    chk("irq",    {15'b0, irq},    {15'b0, m_irq});
    chk("rvalid", {15'b0, rvalid}, {15'b0, m_rvalid});
    chk("rdata",  rdata,           m_rdata);
  endtask

  task automatic idle();
    cs = 1'b0; we = 1'b0; re = 1'b0; addr = 2'd0; wdata = '0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [15:0] got);
    cs = 1'b1; re = 1'b1; we = 1'b0; addr = a;
    cyc();
    got = rdata;
    idle();
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    cs = 1'b1; we = 1'b1; re = 1'b0; addr = a; wdata = d;
    cyc();
    idle();
  endtask

  initial begin
    logic [15:0] got;
    logic [9:0]  v;
    logic [9:0]  prev;

    idle();
    SW  = '0;
    rst = 1'b1;
    model_reset();
    cyc();
    cyc();
    chk("rst_ledr",   {6'b0, LEDR},    16'h0000);
    chk("rst_irq",    {15'b0, irq},    16'h0000);
    chk("rst_rvalid", {15'b0, rvalid}, 16'h0000);
    chk("rst_rdata",  rdata,           16'h0000);
    rst = 1'b0;

    // clean step to 2A5 with interrupts enabled
    wr(A_CTRL, 16'h0001);
    SW = 10'h2A5;
    repeat (6) cyc();
    rd(A_SW, got);  chk("sw_pre_commit", got, 16'h0000);
    rd(A_SW, got);  chk("sw_commit", got, 16'h02A5);
    chk("irq_set", {15'b0, irq}, 16'h0001);
    rd(A_ST, got);  chk("status_first", got, 16'h0001);
    chk("irq_hold", {15'b0, irq}, 16'h0001);
    rd(A_ST, got);  chk("status_second", got, 16'h0000);
    chk("irq_clear", {15'b0, irq}, 16'h0000);

    // return to zero, clear flag, then a 2-cycle glitch must be rejected
    SW = 10'h000;
    repeat (10) cyc();
    rd(A_ST, got);  chk("status_back0", got, 16'h0001);
    SW = 10'h3FF;
    repeat (2) cyc();
    SW = 10'h000;
    repeat (10) cyc();
    rd(A_SW, got);  chk("glitch_sw", got, 16'h0000);
    rd(A_ST, got);  chk("glitch_status", got, 16'h0000);

    // LED register width and read-only SWDATA
    wr(A_LED, 16'hFFFF);
    chk("led_all", {6'b0, LEDR}, 16'h03FF);
    rd(A_LED, got); chk("led_read", got, 16'h03FF);
    wr(A_SW, 16'h1234);
    rd(A_SW, got);  chk("swdata_ro", got, 16'h0000);

    // STATUS read landing on the commit edge keeps chg set
    SW = 10'h0F0;
    repeat (6) cyc();
    rd(A_ST, got);  chk("status_on_commit", got, 16'h0000);
    cs = 1'b1; we = 1'b1; re = 1'b1; addr = A_ST; wdata = 16'h0000;
    cyc();
    idle();
    chk("we_re_no_rvalid", {15'b0, rvalid}, 16'h0000);
    rd(A_ST, got);  chk("status_kept", got, 16'h0001);
    chk("irq_before_rst", {15'b0, irq}, 16'h0001);

    // reset in the middle of a debounce
    SW = 10'h155;
    repeat (5) cyc();
    rst = 1'b1;
    cs = 1'b1; re = 1'b1; addr = A_LED;
    cyc();
    idle();
    rst = 1'b0;
    chk("mid_rst_ledr",   {6'b0, LEDR},    16'h0000);
    chk("mid_rst_irq",    {15'b0, irq},    16'h0000);
    chk("mid_rst_rvalid", {15'b0, rvalid}, 16'h0000);
    chk("mid_rst_rdata",  rdata,           16'h0000);
    repeat (6) cyc();
    rd(A_SW, got);  chk("post_rst_pre", got, 16'h0000);
    rd(A_SW, got);  chk("post_rst_commit", got, 16'h0155);
    rd(A_ST, got);  chk("post_rst_status", got, 16'h0001);

    // firmware-style poll loop on random switch patterns
    prev = SW;
    for (int i = 0; i < 10; i++) begin
      v = 10'($urandom_range(0, 1023));
      if (v == prev) v = v ^ 10'h001;
      SW = v;
      for (int c = 0; c < 20 && LEDR !== v; c += 2) begin
        rd(A_SW, got);
        wr(A_LED, got);
      end
      chk("poll_led", {6'b0, LEDR}, {6'b0, v});
      prev = v;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
